// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV32M multiply/divide unit.
// One operation in flight; shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up at the end.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        kill,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] rd,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_nxt;

   logic [2:0]  op;      // captured funct3
   logic [4:0]  cnt;     // iteration counter
   logic        neg;     // result must be negated in FIX
   logic [31:0] opnd;    // multiplicand or divisor magnitude
   logic [63:0] acc;     // {product hi, product lo / multiplier}, or quotient in [31:0]
   logic [31:0] prem;    // partial remainder (the 33rd bit only lives in the trial subtract)

   logic        accept, is_div, sign1, sign2, neg_in;
   logic        div_zero, div_ovf, special;
   logic [31:0] mag1, mag2, special_rd;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix, fix_rd;

   assign in_ready = (state == IDLE) && !kill;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   // Decode signedness, magnitudes and special cases of the request on the inputs.
   always_comb begin
      is_div     = funct3[2];
      sign1      = rs1[31] && (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
      sign2      = rs2[31] && (funct3 inside {3'd0, 3'd1, 3'd4, 3'd6});
      mag1       = sign1 ? -rs1 : rs1;
      mag2       = sign2 ? -rs2 : rs2;
      // Remainder takes the dividend's sign; everything else the XOR of both.
      neg_in     = (funct3[2] && funct3[1]) ? sign1 : (sign1 ^ sign2);
      div_zero   = is_div && (rs2 == 32'd0);
      div_ovf    = is_div && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
      special    = div_zero || div_ovf;
      // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
      special_rd = 32'd0;
      if (div_zero)     special_rd = funct3[1] ? rs1 : 32'hFFFF_FFFF;
      else if (div_ovf) special_rd = funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   // One shift-add step and one restoring-divide step, evaluated every cycle.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      div_shift = {prem, acc[31]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   // Sign correction and result selection for the FIX state.
   always_comb begin
      prod_fix = neg ? -acc : acc;
      quo_fix  = neg ? -acc[31:0] : acc[31:0];
      rem_fix  = neg ? -prem : prem;
      fix_rd   = 32'd0;
      if (!op[2]) fix_rd = (op[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
      else        fix_rd = op[1] ? rem_fix : quo_fix;
   end

   // Next-state logic; kill overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? DONE : CALC;
         CALC:    if (cnt == 5'd31) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill) state_nxt = IDLE;
   end

   // State register and registered result-valid flag.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt == DONE);
      end
   end

   // Operand capture, iteration datapath and result register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: datapath registers are reset too so no X ever reaches rd or the FIX logic.
      if (rst) begin
         op   <= 3'd0;
         cnt  <= 5'd0;
         neg  <= 1'b0;
         opnd <= 32'd0;
         acc  <= 64'd0;
         prem <= 32'd0;
         rd   <= 32'd0;
      end else if (accept) begin
         op   <= funct3;
         cnt  <= 5'd0;
         neg  <= neg_in;
         prem <= 32'd0;
         if (is_div) begin
            opnd <= mag2;
            acc  <= {32'd0, mag1};
         end else begin
            opnd <= mag1;
            acc  <= {32'd0, mag2};
         end
         if (special) rd <= special_rd;
      end else if (state == CALC) begin
         cnt <= cnt + 5'd1;
         if (!op[2]) begin
            acc <= {mul_sum, acc[31:1]};
         end else if (!div_diff[32]) begin
            prem       <= div_diff[31:0];
            acc[31:0]  <= {acc[30:0], 1'b1};
         end else begin
            prem       <= div_shift[31:0];
            acc[31:0]  <= {acc[30:0], 1'b0};
         end
      end else if (state == FIX && !kill) begin
         rd <= fix_rd;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and scoreboarded bench for muldiv_seq.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, kill, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2, rd;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] mon_exp;
   string       mon_name;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk       (clk),
      .rst       (rst),
      .kill      (kill),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd        (rd),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, want);
      end
   endtask

   // Reference model built on plain 64-bit arithmetic and SV division.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xs1, xu1, xs2, xu2, p;
      int          sa, sb;
      logic        ovf;
      xs1 = {{32{a[31]}}, a};
      xu1 = {32'd0, a};
      xs2 = {{32{b[31]}}, b};
      xu2 = {32'd0, b};
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      model = 32'd0;
      case (f)
         3'd0: begin p = xs1 * xs2; model = p[31:0];  end
         3'd1: begin p = xs1 * xs2; model = p[63:32]; end
         3'd2: begin p = xs1 * xu2; model = p[63:32]; end
         3'd3: begin p = xu1 * xu2; model = p[63:32]; end
         3'd4: model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
         3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: model = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Scoreboard: pop and compare on every result handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'd0);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check({"rd_", mon_name}, rd, mon_exp);
         end
      end
   end

   // Present a request and let it be accepted on the next edge.
   task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name, input bit push);
      @(posedge clk); #1;
      funct3 = f; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      if (push) begin
         exp_q.push_back(exp);
         name_q.push_back(name);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      funct3   = 3'($urandom);
      rs1      = $urandom;
      rs2      = $urandom;
   endtask

   // Count negedges after the accept edge until out_valid shows up.
   task automatic wait_result(input int exp_lat, input string name, output bit seen);
      int k;
      seen = 1'b0;
      k    = 0;
      while (k < 60 && !seen) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
         else k++;
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'(out_valid), 32'd1);
         exp_q.delete();
         name_q.delete();
      end else begin
         check({name, "_latency"}, 32'(k), 32'(exp_lat));
      end
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
      bit seen;
      issue_op(f, a, b, exp, name, 1'b1);
      wait_result(lat, name, seen);
      if (seen) begin
         @(negedge clk);
         check({name, "_one_cycle"}, 32'(out_valid), 32'd0);
         check({name, "_idle_after"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          seen, ov, special;
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul"};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh"};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu"};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu"};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div"};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem"};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33, "divu"};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33, "remu"};
      vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0,  "div_by0"};
      vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         0,  "remu_by0"};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0,  "div_ovf"};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0,  "rem_ovf"};

      // Reset values, including in_ready while rst is still asserted.
      #1;
      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_busy",      32'(busy),      32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_rd",        rd,             32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 12; i++)
         do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // Random vectors against the reference model.
      for (int i = 0; i < 12; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         rb = (i % 3 == 1) ? 32'($urandom_range(1, 20))  : $urandom;
         if (i == 5) rb = 32'd0;
         special = rf[2] && (rb == 0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
         do_op(rf, ra, rb, model(rf, ra, rb), special ? 0 : 33, $sformatf("rand%0d_f%0d", i, rf));
      end

      // Backpressure: result held for 10 cycles, then handshake and immediate new request.
      issue_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "bp_mulhu", 1'b1);
      out_ready = 1'b0;
      wait_result(33, "bp_mulhu", seen);
      for (int i = 0; i < 10; i++) begin
         check("bp_rd_stable", rd,               32'hFFFF_FFFE);
         check("bp_in_ready",  32'(in_ready),    32'd0);
         check("bp_busy",      32'(busy),        32'd1);
         check("bp_out_valid", 32'(out_valid),   32'd1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
      @(negedge clk);
      check("bp_no_accept_in_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("bp_idle_busy",      32'(busy),      32'd0);
      check("bp_idle_in_ready",  32'(in_ready),  32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);
      exp_q.push_back(32'd14);
      name_q.push_back("bp_next_divu");
      @(posedge clk); #1;
      in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
      wait_result(33, "bp_next_divu", seen);
      @(negedge clk);

      // Kill 10 cycles into CALC while a new request is also presented.
      issue_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "kill_op", 1'b0);
      repeat (9) @(posedge clk);
      #1;
      kill = 1'b1; in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
      @(negedge clk);
      check("kill_in_ready_low", 32'(in_ready), 32'd0);
      check("kill_busy_before",  32'(busy),     32'd1);
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("kill_in_ready_after", 32'(in_ready),  32'd1);
      check("kill_busy_after",     32'(busy),      32'd0);
      check("kill_out_valid",      32'(out_valid), 32'd0);
      ov = 1'b0;
      repeat (40) begin
         @(negedge clk);
         ov |= out_valid;
      end
      check("kill_no_result", 32'(ov), 32'd0);

      // Asynchronous reset mid-CALC.
      issue_op(3'd5, 32'd1000, 32'd3, 32'd0, "rst_op", 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rd",        rd,             32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      ov = 1'b0;
      repeat (40) begin
         @(negedge clk);
         ov |= out_valid;
      end
      check("rst_no_result", 32'(ov), 32'd0);
      check("rst_no_pending", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
